// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types and constants for the instruction encoder.
//   fmt_e        : field-set format (I / S / B / reserved)
//   enc_state_e  : encoder session FSM states
//   NOP_WORD     : word written in place of a rejected field set (addi x0,x0,0)
//   IMM*_MIN/MAX : legal immediate ranges per format
//   imm_in_range : signed range test helper
package riscv_pkg;

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_B   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FLUSH = 2'b10
  } enc_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // 12-bit signed immediates (I, S)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  // 13-bit signed branch offset, always even
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  function automatic logic imm_in_range(input logic signed [31:0] v,
                                        input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if -- session control, field-set stream and imem write bus.
//   start/base_addr/n_instr : session launch (producer -> encoder)
//   in_valid/in_ready/in_*  : field-set handshake (producer -> encoder)
//   imem_we/addr/wdata      : instruction-memory write port (encoder -> memory)
//   busy/done/err_cnt       : session status (encoder -> producer)
// master = producer/observer side, slave = encoder side.
interface instr_encoder_if;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] n_instr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;

  modport master (
    output start, base_addr, n_instr, in_valid, in_fmt, in_opcode,
           in_funct3, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_cnt
  );

  modport slave (
    input  start, base_addr, n_instr, in_valid, in_fmt, in_opcode,
           in_funct3, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_cnt
  );
endinterface

// File: rtl/instr_encoder_imm_packer.sv
// imm_packer -- combinational field packing and immediate range check.
//   fmt, opcode, funct3, rd, rs1, rs2, imm : one field set
//   word  : packed instruction (don't-care when legal = 0)
//   legal : field set may be written as-is
// Build option: INSTR_ENCODER_BTYPE_EN adds B-format packing; without it
// fmt 10 reports illegal and no B logic exists.
module imm_packer
  import riscv_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_e'(fmt))
      FMT_I: begin
        word  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
`ifdef INSTR_ENCODER_BTYPE_EN
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = imm_in_range(imm, IMM13_MIN, IMM13_MAX) && !imm[0];
      end
`endif
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- streams field sets into instruction-memory writes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_encoder_if.slave (session control, field-set
//              handshake, imem write port, busy/done/err_cnt status)
// A session writes n_instr words at base_addr + 4k, one cycle after each
// handshake. Rejected field sets are written as NOP and counted.
// Build option: INSTR_ENCODER_BTYPE_EN enables B-format encoding.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  localparam int STAGES = 1;

  enc_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [15:0] n_q;
  logic [15:0] cnt_q;
  logic [15:0] err_q;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;
  logic [STAGES:0] vld_pipe;

  logic        hs;
  logic        start_ok;
  logic        last;
  logic [31:0] pk_word;
  logic        pk_legal;

  imm_packer u_packer (
    .fmt    (bus.in_fmt),
    .opcode (bus.in_opcode),
    .funct3 (bus.in_funct3),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .imm    (bus.in_imm),
    .word   (pk_word),
    .legal  (pk_legal)
  );

  assign bus.in_ready = (state_q == ST_LOAD);
  assign hs           = bus.in_valid && bus.in_ready;
  assign start_ok     = bus.start && (state_q == ST_IDLE);
  // n_q >= 1 whenever we are in LOAD, so the subtract never wraps there
  assign last         = (cnt_q == n_q - 16'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = (bus.n_instr == 16'd0) ? ST_FLUSH : ST_LOAD;
      end
      ST_LOAD: begin
        if (hs && last) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Write echo: stage 0 is the handshake, stage 1 the registered strobe.
  assign vld_pipe[0] = hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (start_ok) begin
        addr_q <= bus.base_addr;
        n_q    <= bus.n_instr;
        cnt_q  <= '0;
        err_q  <= '0;
      end
      if (hs) begin
        waddr_q <= addr_q;
        wdata_q <= pk_legal ? pk_word : NOP_WORD;
        addr_q  <= addr_q + 32'd4;   // wraps mod 2^32
        cnt_q   <= cnt_q + 16'd1;
        if (!pk_legal && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
      end
    end
  end

  assign bus.imem_we    = vld_pipe[STAGES];
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_FLUSH);
  assign bus.err_cnt    = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  one-cycle pulse; begins a load session; honoured only in IDLE.
REQ-004 base_addr  input  32  byte address of first word written; latched on accepted start.
REQ-005 n_instr  input  16  number of instructions in the session; latched on accepted start.
REQ-006 in_valid  input  1  producer has a field set on the in_* inputs.
REQ-007 in_ready  output  1  encoder accepts a field set this cycle.
REQ-008 in_fmt  input  2  format: 00 = I, 01 = S, 10 = B, 11 = reserved.
REQ-009 in_opcode / in_funct3 / in_rd / in_rs1 / in_rs2  input  7/3/5/5/5  instruction fields.
REQ-010 in_imm  input  32  signed immediate, two's complement.
REQ-011 imem_we  output  1  instruction-memory write strobe.
REQ-012 imem_addr  output  32  byte write address.
REQ-013 imem_wdata  output  32  encoded instruction word.
REQ-014 busy  output  1  high in LOAD and FLUSH.
REQ-015 done  output  1  one-cycle pulse at session end.
REQ-016 err_cnt  output  16  count of rejected field sets in the current session.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, FLUSH, with transitions as follows.
- IDLE -> LOAD on start when n_instr != 0.
- IDLE -> FLUSH on start when n_instr == 0.
- LOAD -> FLUSH on the handshake that accepts the n_instr-th field set.
- FLUSH -> IDLE after one cycle; done is pulsed in FLUSH.
REQ-018 in_ready SHALL equal (state == LOAD); a handshake is in_valid && in_ready.
REQ-019 Each handshake SHALL produce exactly one imem write on the next cycle (latency 1). Output registers: imem_we, imem_addr, imem_wdata.
REQ-020 The write address SHALL be base_addr + 4*k for the k-th accepted set (k from 0). Address wraps modulo 2^32.
REQ-021 I-format packing SHALL be {imm[11:0], rs1, funct3, rd, opcode}. Legal range -2048..2047.
REQ-022 S-format packing SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Legal range -2048..2047.
REQ-023 B-format packing SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Legal range -4096..4094 with imm[0] == 0.
REQ-024 A rejected set SHALL still be written, with imem_wdata = 0x00000013 (NOP), and SHALL increment err_cnt by 1. Rejected sets are: out-of-range immediate, fmt 11, or B when disabled. err_cnt saturates at 0xFFFF.
REQ-025 err_cnt SHALL clear on an accepted start. It holds its value after done until the next start.
REQ-026 A start pulse outside IDLE SHALL be ignored, with no effect on the session.
REQ-027 A start pulse asserted in the same cycle as done SHALL be ignored, because the FSM is in FLUSH.
REQ-028 imem_we SHALL be low in every cycle that is not the one-cycle-later echo of a handshake.

Reset
REQ-029 rst SHALL force, on the next edge, all of the following:
- state = IDLE
- in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0
- busy = 0, done = 0, err_cnt = 0
- internal counters = 0
REQ-030 rst during LOAD SHALL abandon the session. The write echo of a handshake in the reset cycle is suppressed, and done is not pulsed.

Configuration
REQ-031 Macro INSTR_ENCODER_BTYPE_EN: when defined, fmt 10 SHALL encode per REQ-023.
REQ-032 When INSTR_ENCODER_BTYPE_EN is undefined, fmt 10 SHALL be rejected per REQ-024, and no B-packing logic is synthesised.

Structure
REQ-033 Shared package riscv_pkg SHALL hold:
- format enum (FMT_I, FMT_S, FMT_B, FMT_RSV)
- NOP constant 0x00000013
- encoder state enum
- immediate range limits
REQ-034 Combinational sub-module imm_packer SHALL perform packing and the range check. It outputs word[31:0] and legal. The parent owns the FSM, counters and output registers.

Verification
REQ-035 Load I-format (imm 8, rs1 2, funct3 2, rd 5, opcode 0x03) with base 0x100, n 1 -> write 0x00812283 at 0x100, then done. err_cnt = 0.
REQ-036 Load S-format (imm -4, rs2 5, rs1 2, funct3 2, opcode 0x23) -> imem_wdata 0xFE512E23.
REQ-037 Load I-format with imm 2048, n 1 -> write 0x00000013 and err_cnt = 1. Repeat with fmt 11 -> same response.
REQ-038 Start with n 3 and base 0xFFFFFFF8, with in_valid toggling -> exactly 3 writes, at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. done asserts 1 cycle after the 3rd write's handshake. A start pulsed mid-session is ignored.
REQ-039 Start with n 0 -> no writes; done pulses the cycle after start.
REQ-040 Assert rst in the cycle of the 2nd handshake of an n 4 session -> no further writes and no done; all outputs at reset values.
